// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that puts NUM_CH load/store channels onto one tagged memory port.
// It records which channel owns each outstanding load tag and routes returned data back to that channel.
module mem_req_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_ready,
    output logic [NUM_CH-1:0]          resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [1:0]                 proc2mem_command,
    output logic [ADDR_W-1:0]          proc2mem_addr,
    output logic [DATA_W-1:0]          proc2mem_data,
    input  logic [TAG_W-1:0]           mem2proc_transaction_tag,
    input  logic [DATA_W-1:0]          mem2proc_data,
    input  logic [TAG_W-1:0]           mem2proc_data_tag,
    output logic                       idle,
    output logic                       err_tag
);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam int CNT_W    = $clog2(MAX_OUT + 1);
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NUM_TAGS = 1 << TAG_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]                  r_rr;
    logic [NUM_CH-1:0][CNT_W-1:0]     r_outstanding;
    logic [NUM_TAGS-1:0]              r_tagValid;
    logic [NUM_TAGS-1:0][CH_W-1:0]    r_tagCh;

    logic [NUM_CH-1:0] w_eligible;
    logic [NUM_CH-1:0] w_inc;
    logic [NUM_CH-1:0] w_dec;
    logic              w_grantValid;
    logic [CH_W-1:0]   w_grant;
    logic              w_accept;
    logic              w_allocLoad;
    logic              w_dataTagNz;
    logic              w_respHit;
    logic [CH_W-1:0]   w_respCh;
    logic              w_anyOut;

    function automatic logic [CH_W-1:0] wrapAdd(input logic [CH_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return CH_W'(sum % NUM_CH);
    endfunction

    always_comb begin
        w_eligible = '0;
        w_anyOut   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_eligible[c] = req_valid[c] & (req_write[c] | (r_outstanding[c] < MAX_CNT));
            w_anyOut      = w_anyOut | (r_outstanding[c] != '0);
        end
    end

    // Search starts at the round-robin pointer and wraps; nothing is granted while in reset.
    always_comb begin
        w_grantValid = 1'b0;
        w_grant      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!rst && !w_grantValid && w_eligible[wrapAdd(r_rr, k)]) begin
                w_grantValid = 1'b1;
                w_grant      = wrapAdd(r_rr, k);
            end
        end
    end

    always_comb begin
        w_accept         = w_grantValid && (mem2proc_transaction_tag != '0);
        w_allocLoad      = w_accept && !req_write[w_grant];
        w_dataTagNz      = (mem2proc_data_tag != '0);
        w_respHit        = w_dataTagNz && r_tagValid[mem2proc_data_tag];
        w_respCh         = r_tagCh[mem2proc_data_tag];
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        req_ready        = '0;
        w_inc            = '0;
        w_dec            = '0;
        if (w_grantValid) begin
            proc2mem_command = req_write[w_grant] ? MEM_STORE : MEM_LOAD;
            proc2mem_addr    = req_addr[w_grant*ADDR_W +: ADDR_W];
            proc2mem_data    = req_wdata[w_grant*DATA_W +: DATA_W];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            req_ready[c] = w_accept && (w_grant == CH_W'(c));
            w_inc[c]     = w_allocLoad && (w_grant == CH_W'(c));
            w_dec[c]     = w_respHit && (w_respCh == CH_W'(c));
        end
        idle = !(|req_valid) && !w_anyOut;
    end

    // The allocation is written after the free, so a tag that is freed and reused in the same cycle ends up owned by the new channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr       <= '0;
            r_tagValid <= '0;
            r_tagCh    <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            err_tag    <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (w_respHit) begin
                resp_valid[w_respCh]          <= 1'b1;
                resp_data                     <= mem2proc_data;
                r_tagValid[mem2proc_data_tag] <= 1'b0;
            end else if (w_dataTagNz) begin
                err_tag <= 1'b1;
            end
            if (w_allocLoad) begin
                r_tagValid[mem2proc_transaction_tag] <= 1'b1;
                r_tagCh[mem2proc_transaction_tag]    <= w_grant;
            end
            if (w_accept) begin
                r_rr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_inc[c] && !w_dec[c]) begin
                    r_outstanding[c] <= r_outstanding[c] + CNT_W'(1);
                end else if (w_dec[c] && !w_inc[c]) begin
                    r_outstanding[c] <= r_outstanding[c] - CNT_W'(1);
                end
            end
        end
    end

endmodule
